output_post_data_module: RTL

OUTPUT_POST_DATA_MODULE -- requirements
Module: output_post_data_module

---
 rtl/pe_pkg.sv | 20 ++
 rtl/output_post_data_module_col_shifter.sv | 79 +++++++
 rtl/output_post_data_module.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the output post-data block.
// Holds the default frame geometry (padded columns, padded rows, pixel
// width), the derived unpadded image size and the FSM state encoding.
package pe_pkg;

  localparam int COLS        = 34;               // padded columns per frame
  localparam int ROWS        = 26;               // padded bytes per column
  localparam int DATA_W      = 8;                // bits per pixel
  localparam int PIX_PER_COL = ROWS - 2;         // unpadded pixels per column
  localparam int IMG_PIX     = (COLS - 2) * PIX_PER_COL;  // 768
  localparam int ADDR_W      = 10;               // width of o_pix_addr
  localparam int COL_W       = 6;                // width of the column counter

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/output_post_data_module_col_shifter.sv
// col_shifter: holds the unpadded bytes of one captured column and streams
// them out one pixel per accepted handshake.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   i_load         capture i_load_data / i_base_addr (only while idle)
//   i_load_data    bytes 1..ROWS-2 of the column, byte 1 in the top bits
//   i_base_addr    address of the first pixel of this column
//   i_pix_rdy      downstream ready
//   o_pix_data     current pixel (0 when not valid)
//   o_pix_vld      pixel valid
//   o_pix_addr     current pixel address (0 when not valid)
//   o_last         pulses with the handshake of the final pixel of the column
//
// Handshake: a pixel moves when o_pix_vld and i_pix_rdy are both high on a
// rising edge; while i_pix_rdy is low, data and address hold unchanged.
module col_shifter #(
  parameter int ROWS   = 26,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_load,
  input  logic [(ROWS-2)*DATA_W-1:0] i_load_data,
  input  logic [ADDR_W-1:0]          i_base_addr,
  input  logic                       i_pix_rdy,
  output logic [DATA_W-1:0]          o_pix_data,
  output logic                       o_pix_vld,
  output logic [ADDR_W-1:0]          o_pix_addr,
  output logic                       o_last
);
  import pe_pkg::*;

  localparam int SH_W  = (ROWS - 2) * DATA_W;
  localparam int ROW_W = $clog2(ROWS - 2);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 3);

  logic [SH_W-1:0]   sh_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_q;
  logic              vld_q;
  logic              accept;

  assign accept = vld_q & i_pix_rdy;
  assign o_last = accept & (row_q == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      row_q  <= '0;
      addr_q <= '0;
      vld_q  <= 1'b0;
    end else if (i_load) begin
      sh_q   <= i_load_data;
      row_q  <= '0;
      addr_q <= i_base_addr;
      vld_q  <= 1'b1;
    end else if (accept) begin
      // The next pixel is always at the top of the register.
      sh_q <= sh_q << DATA_W;
      if (row_q == LAST_ROW) begin
        row_q <= '0;
        vld_q <= 1'b0;
      end else begin
        row_q  <= row_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // Outputs are forced to zero between columns so stale bytes never show.
  always_comb begin
    o_pix_vld  = vld_q;
    o_pix_data = vld_q ? sh_q[SH_W-1 -: DATA_W] : '0;
    o_pix_addr = vld_q ? addr_q : '0;
  end

endmodule

// File: rtl/output_post_data_module.sv
// output_post_data_module: strips the one-byte border from a padded frame.
// Padded columns arrive one per handshake; the first and last column of the
// frame are dropped, each remaining column yields its inner ROWS-2 bytes as
// a stream of pixels with a linear address, and a one-cycle pulse marks the
// end of the frame.
//
// Optional feature macro: PAD_CHECK_EN adds o_pad_err, a sticky flag that
// reports padding bytes that differ from i_padding.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   i_col_data     padded column, byte 0 in the top DATA_W bits
//   i_col_vld      column valid
//   o_col_rdy      column ready (high only while idle)
//   i_sof          start of frame, sampled with an accepted column
//   i_padding      expected padding value
//   o_pix_data     unpadded pixel
//   o_pix_vld      pixel valid
//   i_pix_rdy      downstream ready
//   o_pix_addr     linear pixel address 0..767
//   o_frame_done   one-cycle end-of-frame pulse
//   o_pad_err      sticky padding error (PAD_CHECK_EN only)
//   o_dbg_state    current FSM state (pe_pkg::state_t encoding)
//
// Handshakes: a column is taken when i_col_vld and o_col_rdy are high on a
// rising edge; a pixel is taken when o_pix_vld and i_pix_rdy are high on a
// rising edge. Neither valid depends combinationally on its ready.
module output_post_data_module #(
  parameter int COLS   = pe_pkg::COLS,
  parameter int ROWS   = pe_pkg::ROWS,
  parameter int DATA_W = pe_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ROWS*DATA_W-1:0] i_col_data,
  input  logic                   i_col_vld,
  output logic                   o_col_rdy,
  input  logic                   i_sof,
  input  logic [DATA_W-1:0]      i_padding,
  output logic [DATA_W-1:0]      o_pix_data,
  output logic                   o_pix_vld,
  input  logic                   i_pix_rdy,
  output logic [9:0]             o_pix_addr,
  output logic                   o_frame_done,
`ifdef PAD_CHECK_EN
  output logic                   o_pad_err,
`endif
  output logic [1:0]             o_dbg_state
);
  import pe_pkg::*;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q;
  logic [COL_W-1:0]    eff_col;
  logic                run_q;
  logic                accept;
  logic                is_pad_col;
  logic                load;
  logic                last;
  logic [ADDR_W-1:0]   base_addr;

  // A start-of-frame column restarts counting at column 0.
  assign eff_col    = i_sof ? '0 : col_q;
  assign is_pad_col = (eff_col == '0) || (eff_col == LAST_COL);
  assign accept     = i_col_vld & o_col_rdy;
  assign base_addr  = ADDR_W'((ADDR_W'(eff_col) - ADDR_W'(1)) * ADDR_W'(ROWS - 2));

  // run_q keeps o_col_rdy low during reset and for the release cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (eff_col == LAST_COL)  state_d = S_DONE;
          else if (eff_col != '0)   state_d = S_SHIFT;
        end
      end
      S_SHIFT: if (last) state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_col_rdy    = (state_q == S_IDLE) && run_q;
    o_frame_done = (state_q == S_DONE);
    o_dbg_state  = state_q;
    load         = accept && !is_pad_col;
  end

  // Column counter: advances on discarded columns at accept time and on
  // data columns once their last pixel has left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   col_q <= '0;
    else if (state_q == S_DONE)   col_q <= '0;
    else if (accept && is_pad_col) col_q <= eff_col + 1'b1;
    else if (last)                col_q <= col_q + 1'b1;
  end

  col_shifter #(
    .ROWS   (ROWS),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_col_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (load),
    .i_load_data (i_col_data[(ROWS-1)*DATA_W-1:DATA_W]),
    .i_base_addr (base_addr),
    .i_pix_rdy   (i_pix_rdy),
    .o_pix_data  (o_pix_data),
    .o_pix_vld   (o_pix_vld),
    .o_pix_addr  (o_pix_addr),
    .o_last      (last)
  );

`ifdef PAD_CHECK_EN
  logic pad_bad;

  // Border bytes of every column, and every byte of the border columns.
  always_comb begin
    pad_bad = 1'b0;
    for (int k = 0; k < ROWS; k++) begin
      if (is_pad_col || k == 0 || k == ROWS - 1) begin
        if (i_col_data[(ROWS-1-k)*DATA_W +: DATA_W] != i_padding) pad_bad = 1'b1;
      end
    end
  end

  // Sticky; a clean start-of-frame column is the only non-reset way out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_pad_err <= 1'b0;
    end else if (accept) begin
      if (i_sof)        o_pad_err <= pad_bad;
      else if (pad_bad) o_pad_err <= 1'b1;
    end
  end
`else
  logic unused_pad_inputs;
  assign unused_pad_inputs = ^{i_padding,
                               i_col_data[ROWS*DATA_W-1 -: DATA_W],
                               i_col_data[DATA_W-1:0]};
`endif

endmodule
